// File: rtl/mem_block_copier_if.sv
// mem_block_copier_if: control and RAM-port bundle for the block copy engine
//   master: the engine (drives wrEn/addr_toRAM/data_toRAM/busy/done)
//   slave : requester plus RAM (drives start/src_addr/dst_addr/len/abort/data_fromRAM)
interface mem_block_copier_if #(
    parameter int SIZE  = 14,
    parameter int LEN_W = 14
);
    logic             start;
    logic [SIZE-1:0]  src_addr;
    logic [SIZE-1:0]  dst_addr;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic [31:0]      data_fromRAM;
    logic             wrEn;
    logic [SIZE-1:0]  addr_toRAM;
    logic [31:0]      data_toRAM;
    logic             busy;
    logic             done;

    modport master (
        input  start, src_addr, dst_addr, len, abort, data_fromRAM,
        output wrEn, addr_toRAM, data_toRAM, busy, done
    );

    modport slave (
        output start, src_addr, dst_addr, len, abort, data_fromRAM,
        input  wrEn, addr_toRAM, data_toRAM, busy, done
    );
endinterface

// File: rtl/mem_block_copier.sv
// mem_block_copier: DMA engine copying len words src->dst over a 1-cycle-latency RAM port
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mem_block_copier_if.master (start/src_addr/dst_addr/len/abort in,
//         data_fromRAM in, wrEn/addr_toRAM/data_toRAM/busy/done out)
module mem_block_copier #(
    parameter int SIZE  = 14,
    parameter int LEN_W = 14
) (
    input logic                 clk,
    input logic                 rst,
    mem_block_copier_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t           state_q, state_d;
    logic [SIZE-1:0]  src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, idx_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        idx_inc = idx_q + 1'b1;
        case (state_q)
            IDLE: if (bus.start) begin
                src_d   = bus.src_addr;
                dst_d   = bus.dst_addr;
                len_d   = bus.len;
                idx_d   = '0;
                state_d = (bus.len != '0) ? RD : FIN;
            end
            RD: state_d = bus.abort ? IDLE : WR;
            // The write of this cycle commits regardless of abort; only the next step is cancelled.
            WR: begin
                idx_d   = idx_inc;
                state_d = bus.abort ? IDLE : (idx_inc == len_q) ? FIN : RD;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q == RD) || (state_q == WR);
    assign bus.wrEn       = (state_q == WR);
    assign bus.done       = (state_q == FIN);
    assign bus.addr_toRAM = (state_q == RD) ? src_q + SIZE'(idx_q) :
                            (state_q == WR) ? dst_q + SIZE'(idx_q) : '0;
    // RAM read data from the RD cycle is forwarded straight into the write.
    assign bus.data_toRAM = (state_q == WR) ? bus.data_fromRAM : '0;
endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: table-driven and randomized checks of mem_block_copier against a word-copy model
module tb_mem_block_copier;
    localparam int SIZE  = 14;
    localparam int LEN_W = 14;
    localparam int DEPTH = 1 << SIZE;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_block_copier_if #(.SIZE(SIZE), .LEN_W(LEN_W)) bus();
    mem_block_copier #(.SIZE(SIZE), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0]     mem     [DEPTH];
    logic [31:0]     ref_mem [DEPTH];
    logic            bd_we = 1'b0;
    logic [SIZE-1:0] bd_addr = '0;
    logic [31:0]     bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.wrEn) mem[bus.addr_toRAM] <= bus.data_toRAM;
        bus.data_fromRAM <= mem[bus.addr_toRAM];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] s;
        logic [13:0] d;
        logic [13:0] n;
        int ab;
        int gl;
        int e_busy;
        int e_wr;
        int e_done;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [13:0] a, input logic [31:0] v);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic preload(input logic [13:0] s, input logic [13:0] d, input logic [13:0] n);
        for (int i = -1; i <= int'(n) + 1; i++) begin
            poke(d + 14'(i), $urandom);
            poke(s + 14'(i), $urandom);
        end
    endtask

    task automatic cmp_region(input string nm, input logic [13:0] s, input logic [13:0] d, input logic [13:0] n);
        int bad = 0;
        logic [13:0] a;
        for (int i = -1; i <= int'(n) + 1; i++) begin
            a = d + 14'(i);
            if (mem[a] !== ref_mem[a]) bad++;
            a = s + 14'(i);
            if (mem[a] !== ref_mem[a]) bad++;
        end
        chk(nm, bad, 0);
    endtask

    // Cycle k=1 is the first cycle after the accepting edge. Word i is read in cycle 2i+1
    // and written in cycle 2i+2; done follows in cycle 2n+1 unless an abort cut the copy.
    task automatic run(input logic [13:0] s, input logic [13:0] d, input logic [13:0] n,
                       input int ab, input int gl,
                       output int busy_c, output int wr_c, output int done_k, output int bad);
        logic [13:0] ea;
        int i;
        bit aborted;
        busy_c = 0;
        wr_c = 0;
        done_k = 0;
        bad = 0;
        bus.start = 1'b1;
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.len = n;
        bus.abort = (ab == 0);
        @(negedge clk);
        for (int k = 1; k <= 2 * int'(n) + 8; k++) begin
            bus.abort = (k == ab);
            bus.start = (k == gl);
            bus.src_addr = s + 14'd1000;
            bus.dst_addr = d + 14'd3;
            bus.len = 14'd5;
            if (bus.busy) busy_c++;
            if (bus.wrEn) wr_c++;
            if (bus.done) begin
                if (done_k == 0) done_k = k;
                else bad++;
            end
            aborted = (ab > 0) && (k > ab);
            if (!aborted && k <= 2 * int'(n)) begin
                i = (k - 1) / 2;
                if (k % 2 == 1) begin
                    ea = s + 14'(i);
                    if (!bus.busy || bus.wrEn || bus.done || bus.addr_toRAM !== ea || bus.data_toRAM !== 32'd0) bad++;
                end else begin
                    ea = d + 14'(i);
                    if (!bus.busy || !bus.wrEn || bus.done || bus.addr_toRAM !== ea ||
                        bus.data_toRAM !== ref_mem[s + 14'(i)]) bad++;
                    ref_mem[ea] = ref_mem[s + 14'(i)];
                end
            end else if (!aborted && k == 2 * int'(n) + 1) begin
                if (!bus.done || bus.busy || bus.wrEn || bus.addr_toRAM !== 14'd0 || bus.data_toRAM !== 32'd0) bad++;
            end else if (bus.done || bus.busy || bus.wrEn || bus.addr_toRAM !== 14'd0 || bus.data_toRAM !== 32'd0) begin
                bad++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int bc, wc, dk, bad, ab, idle_bad;
        logic [13:0] s, d, n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len = '0;

        tbl[0] = '{14'd50,    14'd60,  14'd2, -1, -1, 4, 2, 5};
        tbl[1] = '{14'd5,     14'd7,   14'd0, -1, -1, 0, 0, 1};
        tbl[2] = '{14'd10,    14'd11,  14'd3, -1, -1, 6, 3, 7};
        tbl[3] = '{14'd16382, 14'd100, 14'd3, -1, -1, 6, 3, 7};
        tbl[4] = '{14'd200,   14'd300, 14'd4,  4,  2, 4, 2, 0};
        tbl[5] = '{14'd500,   14'd600, 14'd1, -1, -1, 2, 1, 3};
        tbl[6] = '{14'd900,   14'd950, 14'd4,  3, -1, 3, 1, 0};
        tbl[7] = '{14'd1200,  14'd1300, 14'd4, 1, -1, 1, 0, 0};
        tbl[8] = '{14'd1500,  14'd1600, 14'd1, -1,  3, 2, 1, 3};
        tbl[9] = '{14'd1800,  14'd1900, 14'd2,  0, -1, 4, 2, 5};

        repeat (2) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_wrEn", bus.wrEn, 0);
        chk("reset_addr", bus.addr_toRAM, 0);
        chk("reset_data", bus.data_toRAM, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 10; t++) begin
            preload(tbl[t].s, tbl[t].d, tbl[t].n);
            run(tbl[t].s, tbl[t].d, tbl[t].n, tbl[t].ab, tbl[t].gl, bc, wc, dk, bad);
            chk($sformatf("tbl%0d_busy_cycles", t), bc, tbl[t].e_busy);
            chk($sformatf("tbl%0d_writes", t), wc, tbl[t].e_wr);
            chk($sformatf("tbl%0d_done_cycle", t), dk, tbl[t].e_done);
            chk($sformatf("tbl%0d_cycle_pattern", t), bad, 0);
            cmp_region($sformatf("tbl%0d_memory", t), tbl[t].s, tbl[t].d, tbl[t].n);
        end

        poke(14'd10, 32'd1);
        poke(14'd11, 32'd2);
        poke(14'd12, 32'd3);
        poke(14'd13, 32'd85);
        run(14'd10, 14'd11, 14'd3, -1, -1, bc, wc, dk, bad);
        chk("overlap_mem10", mem[10], 1);
        chk("overlap_mem11", mem[11], 1);
        chk("overlap_mem12", mem[12], 1);
        chk("overlap_mem13", mem[13], 1);

        preload(14'd700, 14'd800, 14'd8);
        bus.start = 1'b1;
        bus.src_addr = 14'd700;
        bus.dst_addr = 14'd800;
        bus.len = 14'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_addr", bus.addr_toRAM, 702);
        ref_mem[800] = ref_mem[700];
        ref_mem[801] = ref_mem[701];
        rst = 1'b0;
        #1;
        chk("async_reset_busy", bus.busy, 0);
        chk("async_reset_wrEn", bus.wrEn, 0);
        chk("async_reset_addr", bus.addr_toRAM, 0);
        chk("async_reset_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b1;
        idle_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy || bus.wrEn || bus.done) idle_bad++;
        end
        chk("post_reset_idle", idle_bad, 0);
        cmp_region("post_reset_memory", 14'd700, 14'd800, 14'd8);
        preload(14'd2000, 14'd2100, 14'd1);
        run(14'd2000, 14'd2100, 14'd1, -1, -1, bc, wc, dk, bad);
        chk("post_reset_copy_done", dk, 3);
        chk("post_reset_copy_writes", wc, 1);
        cmp_region("post_reset_copy_memory", 14'd2000, 14'd2100, 14'd1);

        for (int r = 0; r < 20; r++) begin
            s = 14'($urandom);
            d = ($urandom_range(0, 1) == 0) ? 14'($urandom) : s + 14'($urandom_range(0, 4));
            n = 14'($urandom_range(0, 12));
            ab = (n != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * int'(n))) : -1;
            preload(s, d, n);
            run(s, d, n, ab, -1, bc, wc, dk, bad);
            chk($sformatf("rnd%0d_busy_cycles", r), bc, ab > 0 ? ab : 2 * int'(n));
            chk($sformatf("rnd%0d_writes", r), wc, ab > 0 ? ab / 2 : int'(n));
            chk($sformatf("rnd%0d_done_cycle", r), dk, ab > 0 ? 0 : 2 * int'(n) + 1);
            chk($sformatf("rnd%0d_cycle_pattern", r), bad, 0);
            cmp_region($sformatf("rnd%0d_memory", r), s, d, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
